// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM encoding,
// default parameter values and the id-width helper.
package irq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } irq_state_t;

    localparam int          DEF_NIRQ       = 4;
    localparam int          DEF_VEC_W      = 10;
    localparam logic [9:0]  DEF_VEC_BASE   = 10'd1008;
    localparam int          DEF_VEC_STRIDE = 4;

    // Width of a line index; never less than one bit.
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// Per-line input conditioning: two-flop synchronizer followed by a rising
// edge detector. A line already high when reset releases yields one pulse.
module irq_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // Synchronize the raw line and remember the previous synchronized value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= irq_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // One-cycle pulse on a 0->1 transition of the synchronized line.
    always_comb begin
        pulse = sync2 & ~prev;
    end

endmodule

// File: rtl/irq_controller.sv
// Vectored interrupt controller. Edges on external lines set pending
// latches; enabled pending lines are resolved lowest-index-first and offered
// to the CPU as one vector.
//
// Handshake: int_req stays high with a stable int_vec/int_id until the CPU
// samples int_ack=1 on a rising clk edge; that edge clears pending[id] and
// enters service. reti=1 sampled during service returns to idle. int_ack
// outside a request and reti outside service are ignored.
module irq_controller
    import irq_pkg::*;
#(
    parameter int                 NIRQ       = DEF_NIRQ,
    parameter int                 VEC_W      = DEF_VEC_W,
    parameter logic [VEC_W-1:0]   VEC_BASE   = VEC_W'(DEF_VEC_BASE),
    parameter int                 VEC_STRIDE = DEF_VEC_STRIDE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NIRQ-1:0]           irq,
    input  logic                      mask_we,
    input  logic [NIRQ-1:0]           mask_wd,
    input  logic                      int_ack,
    input  logic                      reti,
    output logic                      int_req,
    output logic [VEC_W-1:0]          int_vec,
    output logic [id_width(NIRQ)-1:0] int_id,
    output logic                      in_service,
    output logic [NIRQ-1:0]           pending
);

    localparam int ID_W = id_width(NIRQ);

    irq_state_t      state;
    irq_state_t      state_next;
    logic [NIRQ-1:0] edge_pulse;
    logic [NIRQ-1:0] mask_q;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] clr_mask;
    logic [ID_W-1:0] sel_id;
    logic [VEC_W-1:0] sel_vec;
    logic            capture;
    logic            ack_take;

    genvar g;
    generate
        for (g = 0; g < NIRQ; g++) begin : g_sync
            irq_sync_edge u_sync (
                .clk    (clk),
                .reset  (reset),
                .irq_in (irq[g]),
                .pulse  (edge_pulse[g])
            );
        end
    endgenerate

    // Software-written enable mask.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
        end else if (mask_we) begin
            mask_q <= mask_wd;
        end
    end

    // Clear mask for the line being acknowledged this cycle.
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < NIRQ; i++) begin
            clr_mask[i] = ack_take && (int_id == ID_W'(i));
        end
    end

    // Pending latches: set regardless of mask, and a new edge beats a clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr_mask) | edge_pulse;
        end
    end

    // Fixed priority: lowest index wins; vector computed in VEC_W bits.
    always_comb begin
        eligible = pending & mask_q;
        sel_id   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_id = ID_W'(i);
            end
        end
        sel_vec = VEC_BASE + VEC_W'(VEC_STRIDE) * VEC_W'(sel_id);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic. Leaving service always passes through idle,
    // giving the CPU one instruction before the next request.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ack_take   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (|eligible) begin
                    capture    = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (reti) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Registered outputs; id and vector are frozen at capture time so later
    // arrivals or mask writes cannot disturb an outstanding request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            int_req    <= 1'b0;
            in_service <= 1'b0;
            int_id     <= '0;
            int_vec    <= '0;
        end else begin
            int_req    <= (state_next == ST_REQ);
            in_service <= (state_next == ST_SERVICE);
            if (capture) begin
                int_id  <= sel_id;
                int_vec <= sel_vec;
            end
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Directed bench for irq_controller: linear stimulus with hand-computed
// expected values, checked by immediate assertions.
module tb_irq_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_wd;
    logic       int_ack;
    logic       reti;
    logic       int_req;
    logic [9:0] int_vec;
    logic [1:0] int_id;
    logic       in_service;
    logic [3:0] pending;

    int checks = 0;
    int errors = 0;

    irq_controller dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_wd    (mask_wd),
        .int_ack    (int_ack),
        .reti       (reti),
        .int_req    (int_req),
        .int_vec    (int_vec),
        .int_id     (int_id),
        .in_service (in_service),
        .pending    (pending)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_wd = m;
        tick();
        mask_we = 1'b0;
    endtask

    // Raise lines for 3 cycles; pending is set at the third edge.
    task automatic pulse_irq(input logic [3:0] lines);
        irq = lines;
        tick(3);
        irq = 4'b0000;
    endtask

    task automatic do_ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1;
        tick();
        reti = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        irq     = '0;
        mask_we = 1'b0;
        mask_wd = '0;
        int_ack = 1'b0;
        reti    = 1'b0;
        tick(3);
        chk("rst_req", 32'(int_req), 32'd0);
        chk("rst_vec", 32'(int_vec), 32'd0);
        chk("rst_id", 32'(int_id), 32'd0);
        chk("rst_svc", 32'(in_service), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        reset = 1'b0;
        tick(2);

        // Stray ack/reti in idle are ignored.
        int_ack = 1'b1;
        reti    = 1'b1;
        tick();
        int_ack = 1'b0;
        reti    = 1'b0;
        chk("idle_ign_req", 32'(int_req), 32'd0);
        chk("idle_ign_svc", 32'(in_service), 32'd0);

        // Basic delivery on line 2.
        write_mask(4'b0100);
        pulse_irq(4'b0100);
        chk("basic_pend", 32'(pending), 32'b0100);
        chk("basic_noreq_yet", 32'(int_req), 32'd0);
        tick();
        chk("basic_req", 32'(int_req), 32'd1);
        chk("basic_vec", 32'(int_vec), 32'd1016);
        chk("basic_id", 32'(int_id), 32'd2);
        do_ack();
        chk("basic_ack_pend", 32'(pending), 32'd0);
        chk("basic_ack_svc", 32'(in_service), 32'd1);
        chk("basic_ack_req", 32'(int_req), 32'd0);
        tick(2);
        do_reti();
        chk("basic_reti_svc", 32'(in_service), 32'd0);
        tick();
        chk("basic_idle_req", 32'(int_req), 32'd0);

        // Priority: lines 3 and 1 together, line 1 first.
        write_mask(4'b1111);
        pulse_irq(4'b1010);
        tick();
        chk("prio_req1", 32'(int_req), 32'd1);
        chk("prio_vec1", 32'(int_vec), 32'd1012);
        chk("prio_id1", 32'(int_id), 32'd1);
        do_ack();
        chk("prio_pend", 32'(pending), 32'b1000);
        do_reti();
        chk("prio_idle_gap", 32'(int_req), 32'd0);
        tick();
        chk("prio_req2", 32'(int_req), 32'd1);
        chk("prio_vec2", 32'(int_vec), 32'd1020);
        chk("prio_id2", 32'(int_id), 32'd3);
        do_ack();
        do_reti();
        tick();

        // Masking: line 0 stays pending while disabled.
        write_mask(4'b0000);
        pulse_irq(4'b0001);
        chk("mask_pend", 32'(pending), 32'b0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("mask_noreq", 32'(int_req), 32'd0);
        end
        write_mask(4'b0001);
        chk("mask_wr_noreq", 32'(int_req), 32'd0);
        tick();
        chk("mask_req", 32'(int_req), 32'd1);
        chk("mask_vec", 32'(int_vec), 32'd1008);
        do_ack();
        do_reti();
        tick();

        // No preemption and no nesting.
        write_mask(4'b1111);
        pulse_irq(4'b0100);
        tick();
        chk("npre_req", 32'(int_req), 32'd1);
        pulse_irq(4'b0001);
        chk("npre_vec", 32'(int_vec), 32'd1016);
        chk("npre_id", 32'(int_id), 32'd2);
        chk("npre_pend", 32'(pending), 32'b0101);
        write_mask(4'b0000);
        chk("npre_maskwr_req", 32'(int_req), 32'd1);
        chk("npre_maskwr_vec", 32'(int_vec), 32'd1016);
        write_mask(4'b1111);
        do_ack();
        chk("npre_svc", 32'(in_service), 32'd1);
        chk("npre_svc_pend", 32'(pending), 32'b0001);
        pulse_irq(4'b0001);
        tick(4);
        chk("npre_svc_noreq", 32'(int_req), 32'd0);
        chk("npre_svc_hold", 32'(in_service), 32'd1);
        chk("npre_svc_id", 32'(int_id), 32'd2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("npre_svc_ackign", 32'(in_service), 32'd1);
        do_reti();
        chk("npre_reti_req", 32'(int_req), 32'd0);
        tick();
        chk("npre_req0", 32'(int_req), 32'd1);
        chk("npre_vec0", 32'(int_vec), 32'd1008);
        chk("npre_id0", 32'(int_id), 32'd0);
        reti = 1'b1;
        tick();
        reti = 1'b0;
        chk("req_reti_ign", 32'(int_req), 32'd1);
        do_ack();
        do_reti();
        tick(2);

        // Set/clear collision on line 1.
        pulse_irq(4'b0010);
        tick();
        chk("coll_req", 32'(int_id), 32'd1);
        tick(3);
        irq = 4'b0010;
        tick(2);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        irq = 4'b0000;
        chk("coll_svc", 32'(in_service), 32'd1);
        chk("coll_pend", 32'(pending), 32'b0010);
        tick(3);
        do_reti();
        chk("coll_gap", 32'(int_req), 32'd0);
        tick();
        chk("coll_req2", 32'(int_req), 32'd1);
        chk("coll_id2", 32'(int_id), 32'd1);
        chk("coll_vec2", 32'(int_vec), 32'd1012);
        do_ack();
        chk("coll_pend2", 32'(pending), 32'd0);

        // Asynchronous reset while in service with lines 1 and 3 pending.
        pulse_irq(4'b1010);
        tick();
        chk("rmid_svc", 32'(in_service), 32'd1);
        chk("rmid_pend", 32'(pending), 32'b1010);
        #3;
        reset = 1'b1;
        #1;
        chk("rmid_req", 32'(int_req), 32'd0);
        chk("rmid_svc0", 32'(in_service), 32'd0);
        chk("rmid_pend0", 32'(pending), 32'd0);
        chk("rmid_mask0", 32'(dut.mask_q), 32'd0);
        tick(2);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_noreq", 32'(int_req), 32'd0);
        end
        chk("post_rst_pend", 32'(pending), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Vectored interrupt controller for the single-cycle CPU.
- Sits upstream of the PC next-address mux and the call/return stack.
- Latches edges on external interrupt lines, applies a software-written enable mask and resolves priority.
- Presents one vector to the CPU through a req/ack handshake; the CPU pushes the return PC on ack and pops it on reti.
- No nesting.

Parameters:
- NIRQ, 4, number of interrupt lines (2..8).
- VEC_W, 10, vector width; equals the PC width.
- VEC_BASE, 10'd1008, vector of line 0.
- VEC_STRIDE, 4, address distance between consecutive vectors.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq  in  NIRQ  raw external interrupt lines, asynchronous to clk.
- mask_we  in  1  write enable for the mask register.
- mask_wd  in  NIRQ  new mask value; bit=1 enables the line.
- int_ack  in  1  CPU accepts the pending request (PC pushed this cycle).
- reti  in  1  CPU executes return-from-interrupt.
- int_req  out  1  interrupt request to the CPU.
- int_vec  out  VEC_W  target address while int_req=1.
- int_id  out  clog2(NIRQ)  index of the line being requested or serviced.
- in_service  out  1  handler currently running.
- pending  out  NIRQ  pending latches, for debug/status reads.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: all outputs 0, mask=0 (all lines disabled), FSM=IDLE, synchronizer and edge flops 0.
- Input path:
  - Each irq bit passes a 2-flop synchronizer, then a rising-edge detector (sync2 & ~prev).
  - A line held high through reset release counts as one event.
- Pending latches:
  - An edge sets pending[i] on the next clk edge.
  - Pending latches are set regardless of mask. Masked lines stay pending until enabled.
  - A clear (ack of line i) coinciding with a new edge on line i leaves pending[i]=1. Set wins.
- Eligibility and priority:
  - eligible = pending & mask.
  - Lowest index has the highest priority.
  - int_vec = VEC_BASE + VEC_STRIDE*id, computed modulo 2^VEC_W.
- Mask register:
  - Loaded on clk edge when mask_we=1.
  - A mask write and an edge in the same cycle are independent.
- FSM states: IDLE, REQ, SERVICE.
  - IDLE: if eligible != 0, capture id = highest-priority eligible line and go to REQ.
  - REQ: int_req=1; int_vec and int_id are held from the captured id.
    - Higher-priority arrivals do not preempt the request.
    - Mask changes do not withdraw the request.
    - On int_ack=1: clear pending[id], go to SERVICE.
  - SERVICE: in_service=1, int_req=0, int_id is held.
    - On reti=1: go to IDLE.
    - New events keep accumulating in pending.
  - After reti, IDLE lasts at least one cycle before the next REQ. This gives the CPU one un-interrupted instruction after return.
- Ignored inputs: int_ack outside REQ and reti outside SERVICE are ignored. int_ack and reti asserted together obey the current state only.
- Latency: with irq high before clk edge k, pending is set at edge k+2 and int_req rises after edge k+3. The minimum is 4 edges.
- Timing of outputs: int_req, int_vec, int_id and in_service are registered. No combinational path exists from any input to any output.
- Reset mid-operation: returns immediately to IDLE and drops int_req/in_service asynchronously. Pending and mask are cleared, so lost events are not replayed.
- Width rule: id width is clog2(NIRQ). The vector arithmetic is done in VEC_W bits.

Decomposition:
- Shared package irq_pkg holds:
  - FSM state encoding (IDLE=2'b00, REQ=2'b01, SERVICE=2'b10);
  - default NIRQ, VEC_W, VEC_BASE and VEC_STRIDE constants;
  - a function computing the id width.
- Sub-module irq_sync_edge: one per line, generated NIRQ times. It contains the 2-flop synchronizer plus edge flop and outputs a 1-cycle edge pulse. It uses clk and the async reset.
- Priority encoder and FSM stay in irq_controller.

Test Plan:
- Basic delivery:
  - Stimulus: mask=4'b0100, pulse irq[2] high for 3 cycles.
  - Required response: int_req rises 4 edges later with int_vec=1016 and int_id=2. int_ack → pending[2]=0 and in_service=1. reti → in_service=0.
- Priority:
  - Stimulus: mask=4'b1111, edges on irq[3] and irq[1] in the same cycle.
  - Required response: first request has int_vec=1012 (id 1). After ack+reti plus 1 IDLE cycle, the second request has int_vec=1020 (id 3).
- Masking:
  - Stimulus: mask=0, edge on irq[0].
  - Required response: pending=4'b0001 with no int_req for 20 cycles. Write mask=4'b0001 → int_req 2 edges later with int_vec=1008.
- No preemption / no nesting:
  - Stimulus: while in REQ for id 2, an edge on irq[0]; while in SERVICE, further edges on irq[0].
  - Required response: vector stays 1016 until ack. In SERVICE int_req stays 0. The irq[0] request appears only after reti.
- Set/clear collision:
  - Stimulus: an edge on line 1 lands in the same cycle as int_ack for id 1.
  - Required response: pending[1] remains 1, and a second request for id 1 follows reti.
- Reset mid-service:
  - Stimulus: assert reset asynchronously (between clock edges) while in_service=1 and pending=4'b1010.
  - Required response: immediately int_req=0, in_service=0, pending=0, mask=0. After release with irq held low, no request occurs.
